sonar_ranging_ctrl: RTL
=======================

// Module: sonar_ranging_ctrl
// PURPOSE
//  Sequences an HC-SR04-style ultrasonic ranger for the parking-aid datapath.
//  Issues periodic trigger pulses and times the echo pulse to whole centimetres.
//  Publishes a 12-bit distance on binary_dst, which feeds the proximity/bip logic.
//  A missing echo or an over-long echo reports maximum range (4095 cm), which keeps the buzzer silent.
// PARAMETERS
//  TRIG_CYC          500      trigger high time in clk cycles (10 us @ 50 MHz)
//  CYC_PER_CM        2900     echo cycles per cm (58 us @ 50 MHz)
//  ECHO_TIMEOUT_CYC  1500000  max cycles from WAIT_ECHO entry to echo fall (30 ms)
//  MEAS_PERIOD_CYC   3000000  trigger-to-trigger period (60 ms); must exceed TRIG_CYC+ECHO_TIMEOUT_CYC
// PORTS
//  clk          in   1   system clock, 50 MHz
//  n_rst        in   1   asynchronous active-low reset
//  enable       in   1   1 = run periodic measurements
//  echo         in   1   sensor echo, asynchronous to clk
//  trig         out  1   sensor trigger pulse
//  binary_dst   out  12  last distance in cm, held between updates
//  dst_valid    out  1   1-cycle pulse when binary_dst is updated
//  timeout_err  out  1   1-cycle pulse, coincident with dst_valid, when the result is a timeout
// BEHAVIOUR
//  Reset: clk and n_rst behave as stated above. Outputs reset to trig=0, binary_dst=12'd4095, dst_valid=0, timeout_err=0.
//   The FSM resets to IDLE, and all counters and the echo synchroniser reset to 0.
//  echo passes through a 2-FF synchroniser (echo_s). Rise and fall are edge-detected on echo_s.
//   Synchroniser latency is equal on both edges, so the measured width equals the echo high time (+/-1 cycle).
//  FSM states and transitions:
//   IDLE: trig=0. If enable=1, go to TRIG on the next cycle and clear period_cnt.
//   TRIG: trig=1 for exactly TRIG_CYC cycles, then go to WAIT_ECHO with trig=0. Clear tmo_cnt.
//   WAIT_ECHO: wait for a rising edge of echo_s. An echo already high on entry is ignored until the next rise.
//    On a rise, go to MEASURE and clear sub_cnt and cm_cnt.
//   MEASURE: sub_cnt increments every cycle. When sub_cnt==CYC_PER_CM-1, sub_cnt<=0 and cm_cnt increments.
//    cm_cnt saturates at 4095 with no wrap. On a falling edge of echo_s: binary_dst<=cm_cnt (truncated), dst_valid=1, go to HOLD.
//   Timeout: tmo_cnt runs in WAIT_ECHO and MEASURE.
//    When tmo_cnt==ECHO_TIMEOUT_CYC-1 and there is no fall that cycle: binary_dst<=4095, dst_valid=1, timeout_err=1, go to HOLD.
//    If a fall and the timeout occur in the same cycle, the fall wins and a normal result is reported.
//   HOLD: wait until period_cnt==MEAS_PERIOD_CYC-1.
//    Then go to TRIG (period_cnt cleared) if enable=1, otherwise go to IDLE.
//  period_cnt counts from TRIG entry, so trig rising edges are exactly MEAS_PERIOD_CYC cycles apart while enable stays 1.
//  enable=0 in any state: go to IDLE on the next edge, force trig=0, and abort the measurement.
//   No dst_valid is produced and binary_dst holds its last value.
//  Reset asserted mid-operation: immediate return to the reset values, including binary_dst=4095.
//  dst_valid and timeout_err are registered pulses. binary_dst changes only in the cycle dst_valid=1.
// TESTING (bench parameters: TRIG_CYC=4, CYC_PER_CM=10, ECHO_TIMEOUT_CYC=200, MEAS_PERIOD_CYC=400)
//  1. Assert n_rst low mid-cycle -> trig=0, binary_dst=4095, dst_valid=0 immediately. Stay in IDLE while enable=0.
//  2. Set enable=1, echo high for 253 cycles 20 cycles after trig falls -> trig high for 4 cycles.
//     binary_dst=25 with a single dst_valid pulse and timeout_err=0.
//  3. enable=1, echo never rises -> 200 cycles after trig falls: binary_dst=4095, dst_valid=1, timeout_err=1.
//  4. Echo rises and stays high -> timeout in MEASURE: binary_dst=4095, timeout_err=1.
//     Echo held high into the next period is ignored until it falls and rises again.
//  5. enable held at 1 for 3 periods with a 100-cycle echo each time -> trig rises are exactly 400 cycles apart.
//     binary_dst=10 is reported three times.
//  6. Drop enable halfway through MEASURE -> trig=0, IDLE, no dst_valid, binary_dst unchanged.
//     Re-enable -> a new trig starts 1 cycle later.

Source files
------------

// File: rtl/sonar_ranging_ctrl.sv
`timescale 1ns/1ps
// sonar_ranging_ctrl: sequences an HC-SR04-style ultrasonic ranger.
// It issues a periodic trigger pulse, times the synchronised echo in whole
// centimetres and publishes a 12-bit distance. A missing or over-long echo
// reports 4095 cm.
module sonar_ranging_ctrl #(
  parameter int unsigned TRIG_CYC         = 500,
  parameter int unsigned CYC_PER_CM       = 2900,
  parameter int unsigned ECHO_TIMEOUT_CYC = 1500000,
  parameter int unsigned MEAS_PERIOD_CYC  = 3000000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        enable,
  input  logic        echo,
  output logic        trig,
  output logic [11:0] binary_dst,
  output logic        dst_valid,
  output logic        timeout_err
);

  localparam int unsigned PW = (MEAS_PERIOD_CYC  > 1) ? $clog2(MEAS_PERIOD_CYC)  : 1;
  localparam int unsigned TW = (ECHO_TIMEOUT_CYC > 1) ? $clog2(ECHO_TIMEOUT_CYC) : 1;
  localparam int unsigned SW = (CYC_PER_CM       > 1) ? $clog2(CYC_PER_CM)       : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_ECHO,
    S_MEASURE,
    S_HOLD
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_echo_meta;
  logic            r_echo_s;
  logic            r_echo_d;
  logic            w_echo_rise;
  logic            w_echo_fall;

  logic [PW-1:0]   r_period_cnt;
  logic [TW-1:0]   r_tmo_cnt;
  logic [SW-1:0]   r_sub_cnt;
  logic [11:0]     r_cm_cnt;
  logic [11:0]     w_cm_nxt;

  logic            w_period_end;
  logic            w_trig_end;
  logic            w_tmo_hit;
  logic            w_sub_wrap;

  logic            w_enter_trig;
  logic            w_enter_wait;
  logic            w_start_meas;
  logic            w_done;
  logic            w_done_tmo;

  logic            r_trig;
  logic [11:0]     r_binary_dst;
  logic            r_dst_valid;
  logic            r_timeout_err;

  assign w_echo_rise  = r_echo_s & ~r_echo_d;
  assign w_echo_fall  = ~r_echo_s & r_echo_d;

  // period_cnt runs from TRIG entry, so it also times the trigger pulse
  assign w_period_end = (r_period_cnt == PW'(MEAS_PERIOD_CYC - 1));
  assign w_trig_end   = (r_period_cnt == PW'(TRIG_CYC - 1));
  assign w_tmo_hit    = (r_tmo_cnt == TW'(ECHO_TIMEOUT_CYC - 1));
  assign w_sub_wrap   = (r_sub_cnt == SW'(CYC_PER_CM - 1));

  // Centimetre count including this cycle's tick, so a falling edge reports
  // every cycle the echo was high.
  assign w_cm_nxt = ((r_state == S_MEASURE) && w_sub_wrap && (r_cm_cnt != 12'hFFF))
                    ? r_cm_cnt + 12'd1 : r_cm_cnt;

  // Two-flop synchroniser plus one delay stage for edge detection
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_echo_meta <= 1'b0;
      r_echo_s    <= 1'b0;
      r_echo_d    <= 1'b0;
    end else begin
      r_echo_meta <= echo;
      r_echo_s    <= r_echo_meta;
      r_echo_d    <= r_echo_s;
    end
  end

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; enable=0 overrides everything and aborts silently
  always_comb begin
    w_state_nxt  = r_state;
    w_enter_trig = 1'b0;
    w_enter_wait = 1'b0;
    w_start_meas = 1'b0;
    w_done       = 1'b0;
    w_done_tmo   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_nxt  = S_TRIG;
          w_enter_trig = 1'b1;
        end
      end
      S_TRIG: begin
        if (w_trig_end) begin
          w_state_nxt  = S_WAIT_ECHO;
          w_enter_wait = 1'b1;
        end
      end
      S_WAIT_ECHO: begin
        if (w_tmo_hit) begin
          w_state_nxt = S_HOLD;
          w_done      = 1'b1;
          w_done_tmo  = 1'b1;
        end else if (w_echo_rise) begin
          w_state_nxt  = S_MEASURE;
          w_start_meas = 1'b1;
        end
      end
      S_MEASURE: begin
        // a fall in the timeout cycle still yields a normal result
        if (w_echo_fall) begin
          w_state_nxt = S_HOLD;
          w_done      = 1'b1;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_HOLD;
          w_done      = 1'b1;
          w_done_tmo  = 1'b1;
        end
      end
      S_HOLD: begin
        if (w_period_end) begin
          w_state_nxt  = S_TRIG;
          w_enter_trig = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (!enable) begin
      w_state_nxt  = S_IDLE;
      w_enter_trig = 1'b0;
      w_enter_wait = 1'b0;
      w_start_meas = 1'b0;
      w_done       = 1'b0;
      w_done_tmo   = 1'b0;
    end
  end

  // Period, timeout and echo-width counters
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_period_cnt <= '0;
      r_tmo_cnt    <= '0;
      r_sub_cnt    <= '0;
      r_cm_cnt     <= '0;
    end else begin
      if (w_enter_trig) begin
        r_period_cnt <= '0;
      end else if (r_state != S_IDLE) begin
        r_period_cnt <= r_period_cnt + 1'b1;
      end

      if (w_enter_wait) begin
        r_tmo_cnt <= '0;
      end else if ((r_state == S_WAIT_ECHO) || (r_state == S_MEASURE)) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end

      if (w_start_meas) begin
        r_sub_cnt <= '0;
        r_cm_cnt  <= '0;
      end else if (r_state == S_MEASURE) begin
        r_sub_cnt <= w_sub_wrap ? '0 : r_sub_cnt + 1'b1;
        r_cm_cnt  <= w_cm_nxt;
      end
    end
  end

  // Registered outputs: trigger, result and its one-cycle strobes
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_trig        <= 1'b0;
      r_binary_dst  <= 12'd4095;
      r_dst_valid   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_trig        <= (w_state_nxt == S_TRIG);
      r_dst_valid   <= w_done;
      r_timeout_err <= w_done_tmo;
      if (w_done) begin
        r_binary_dst <= w_done_tmo ? '1 : w_cm_nxt;
      end
    end
  end

  assign trig        = r_trig;
  assign binary_dst  = r_binary_dst;
  assign dst_valid   = r_dst_valid;
  assign timeout_err = r_timeout_err;

endmodule
